// File: rtl/branch_unit.sv
// Program counter, conditional jump evaluation and a small CALL/RET return-address stack.
// All state updates on the rising edge of clk; res clears everything asynchronously.
module branch_unit #(
  parameter int NumStatusBits = 2,
  parameter int PcWidth       = 8,
  parameter int StackDepth    = 4
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          en,
  input  logic [2:0]                    op,
  input  logic [PcWidth-1:0]            target,
  input  logic [NumStatusBits-1:0]      status,
  output logic [PcWidth-1:0]            pc,
  output logic                          taken,
  output logic [$clog2(StackDepth):0]   depth,
  output logic                          stack_err
);

  localparam int AddrWidth  = $clog2(StackDepth);
  localparam int DepthWidth = AddrWidth + 1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_JC   = 3'd4;
  localparam logic [2:0] OP_JNC  = 3'd5;
  localparam logic [2:0] OP_CALL = 3'd6;
  localparam logic [2:0] OP_RET  = 3'd7;

  logic [PcWidth-1:0]    stack [StackDepth];
  logic [PcWidth-1:0]    pc_inc;
  logic [PcWidth-1:0]    pc_next;
  logic [DepthWidth-1:0] depth_next;
  logic                  taken_next;
  logic                  err_next;
  logic                  push;
  logic                  stack_full;
  logic                  stack_empty;
  logic [AddrWidth-1:0]  push_idx;
  logic [AddrWidth-1:0]  pop_idx;
  logic                  flag_z;
  logic                  flag_c;

  // Only Z and C are meaningful; wider status buses carry bits this unit ignores.
  generate
    if (NumStatusBits > 2) begin : g_status_hi
      logic unused_status_hi;
      assign unused_status_hi = ^status[NumStatusBits-1:2];
    end
  endgenerate

  assign flag_z      = status[0];
  assign flag_c      = status[1];
  assign pc_inc      = pc + PcWidth'(1);
  assign stack_full  = (depth == DepthWidth'(StackDepth));
  assign stack_empty = (depth == '0);
  assign push_idx    = depth[AddrWidth-1:0];
  assign pop_idx     = push_idx - AddrWidth'(1);

  always_comb begin
    pc_next    = pc;
    depth_next = depth;
    taken_next = 1'b0;
    err_next   = stack_err;
    push       = 1'b0;
    if (en) begin
      pc_next = pc_inc;
      case (op)
        OP_NOP: ;
        OP_JMP: begin
          pc_next    = target;
          taken_next = 1'b1;
        end
        OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
          if ((op == OP_JZ  &&  flag_z) || (op == OP_JNZ && !flag_z) ||
              (op == OP_JC  &&  flag_c) || (op == OP_JNC && !flag_c)) begin
            pc_next    = target;
            taken_next = 1'b1;
          end
        end
        OP_CALL: begin
          if (stack_full) begin
            err_next = 1'b1;
          end else begin
            push       = 1'b1;
            depth_next = depth + DepthWidth'(1);
            pc_next    = target;
            taken_next = 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_next = 1'b1;
          end else begin
            depth_next = depth - DepthWidth'(1);
            pc_next    = stack[pop_idx];
            taken_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pc        <= '0;
      depth     <= '0;
      taken     <= 1'b0;
      stack_err <= 1'b0;
      for (int i = 0; i < StackDepth; i++) stack[i] <= '0;
    end else begin
      pc        <= pc_next;
      depth     <= depth_next;
      taken     <= taken_next;
      stack_err <= err_next;
      if (push) stack[push_idx] <= pc_inc;
    end
  end

endmodule
